// File: rtl/accum_cpu_param_if.sv
// Host-side bus of the parametrised accumulator CPU.
//   master: the loader/sequencer that drives commands and watches the core state
//   slave : the CPU core
// Signals:
//   cmd_i    0 LOADPROG, 1 LOADDATA, 2 SETPC, 3 RUN
//   valid_i  qualifies cmd_i/data_i
//   data_i   load data, opcode in [3:0], SETPC target in [ADDR_W-1:0]
//   cond_i   external jump condition
//   step_i   single-step enable for RUN
//   acc_o, pc_o, zero_o, carry_o, halted_o  architectural state driven to the pads
interface accum_cpu_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [1:0]        cmd_i;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              cond_i;
  logic              step_i;
  logic [DATA_W-1:0] acc_o;
  logic [ADDR_W-1:0] pc_o;
  logic              zero_o;
  logic              carry_o;
  logic              halted_o;

  modport master (
    output cmd_i, valid_i, data_i, cond_i, step_i,
    input  acc_o, pc_o, zero_o, carry_o, halted_o
  );

  modport slave (
    input  cmd_i, valid_i, data_i, cond_i, step_i,
    output acc_o, pc_o, zero_o, carry_o, halted_o
  );
endinterface

// File: rtl/accum_cpu_param.sv
// Parametrised accumulator CPU. Program (4-bit opcodes) and data (DATA_W words) files are
// loaded through the host bus, then executed one instruction per enabled RUN cycle.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset, clears all state including both memories
//   bus      accum_cpu_param_if.slave: command/data inputs, acc/pc/flags/halted outputs
// Parameters:
//   DATA_W   accumulator and data word width (>=4)
//   ADDR_W   program/data address width, depth 2**ADDR_W
//   STEP_EN  1: RUN only executes on cycles with step_i=1; 0: step_i ignored
module accum_cpu_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int STEP_EN = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  accum_cpu_param_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int SH_W  = $clog2(DATA_W);

  localparam logic [1:0] CMD_LOADPROG = 2'd0;
  localparam logic [1:0] CMD_LOADDATA = 2'd1;
  localparam logic [1:0] CMD_SETPC    = 2'd2;
  localparam logic [1:0] CMD_RUN      = 2'd3;

  localparam logic [3:0] OP_LOAD  = 4'd0,  OP_STORE = 4'd1,  OP_ADD = 4'd2,  OP_MUL  = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4,  OP_SHL   = 4'd5,  OP_SHR = 4'd6,  OP_JIF  = 4'd7;
  localparam logic [3:0] OP_JZ    = 4'd8,  OP_JC    = 4'd9,  OP_EQ  = 4'd10, OP_NEQ  = 4'd11;
  localparam logic [3:0] OP_AND   = 4'd12, OP_OR    = 4'd13, OP_NOT = 4'd14, OP_HALT = 4'd15;

  typedef enum logic {ACTIVE, HALT} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, npc;
  logic [DATA_W-1:0] acc, acc_n;
  logic              z, z_n, c, c_n;
  logic              cond_q, cond_n;

  logic [3:0]        prog_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              prog_we, data_we;
  logic [ADDR_W-1:0] data_wa;
  logic [DATA_W-1:0] data_wd;

  logic [3:0]          op;
  logic [DATA_W-1:0]   d;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  logic                run_en;

  // Shift amounts larger than the word are clamped to DATA_W-1 rather than flushing to zero.
  function automatic logic [SH_W-1:0] shamt_sat(input logic [DATA_W-1:0] amt);
    if (amt > DATA_W'(DATA_W - 1)) return SH_W'(DATA_W - 1);
    else                           return amt[SH_W-1:0];
  endfunction

  assign op   = prog_mem[pc];
  assign d    = data_mem[pc];
  assign npc  = pc + 1'b1;
  assign sum  = {1'b0, acc} + {1'b0, d};
  assign prod = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, d};

  assign run_en = (state == ACTIVE) && ((STEP_EN == 0) || bus.step_i);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    acc_n   = acc;
    z_n     = z;
    c_n     = c;
    cond_n  = cond_q;
    prog_we = 1'b0;
    data_we = 1'b0;
    data_wa = pc;
    data_wd = bus.data_i;
    if (bus.valid_i) begin
      cond_n = bus.cond_i;
      unique case (bus.cmd_i)
        CMD_LOADPROG: begin
          prog_we = 1'b1;
          pc_n    = npc;
        end
        CMD_LOADDATA: begin
          data_we = 1'b1;
          pc_n    = npc;
        end
        CMD_SETPC: begin
          pc_n    = bus.data_i[ADDR_W-1:0];
          state_n = ACTIVE;
        end
        CMD_RUN: begin
          if (run_en) begin
            pc_n = npc;
            unique case (op)
              OP_LOAD:  acc_n = d;
              OP_STORE: begin
                data_we = 1'b1;
                data_wa = d[ADDR_W-1:0];
                data_wd = acc;
              end
              OP_ADD:   {c_n, acc_n} = sum;
              OP_MUL: begin
                acc_n = prod[DATA_W-1:0];
                c_n   = |prod[2*DATA_W-1:DATA_W];
              end
              OP_SUB: begin
                acc_n = acc - d;
                c_n   = (acc < d);
              end
              OP_SHL:   acc_n = acc << shamt_sat(d);
              OP_SHR:   acc_n = acc >> shamt_sat(d);
              OP_JIF:   if (cond_q) pc_n = d[ADDR_W-1:0];
              OP_JZ:    if (z)      pc_n = d[ADDR_W-1:0];
              OP_JC:    if (c)      pc_n = d[ADDR_W-1:0];
              OP_EQ:    acc_n = {{(DATA_W-1){1'b0}}, (acc == d)};
              OP_NEQ:   acc_n = {{(DATA_W-1){1'b0}}, (acc != d)};
              OP_AND:   acc_n = acc & d;
              OP_OR:    acc_n = acc | d;
              OP_NOT:   acc_n = ~acc;
              OP_HALT: begin
                pc_n    = pc;
                state_n = HALT;
              end
              default: ;
            endcase
            // Z tracks the new accumulator only for ops that produce one.
            if (!(op inside {OP_STORE, OP_JIF, OP_JZ, OP_JC, OP_HALT}))
              z_n = (acc_n == '0);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ACTIVE;
      pc     <= '0;
      acc    <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      cond_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        prog_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      acc    <= acc_n;
      z      <= z_n;
      c      <= c_n;
      cond_q <= cond_n;
      if (prog_we) prog_mem[pc]      <= bus.data_i[3:0];
      if (data_we) data_mem[data_wa] <= data_wd;
    end
  end

  assign bus.acc_o    = acc;
  assign bus.pc_o     = pc;
  assign bus.zero_o   = z;
  assign bus.carry_o  = c;
  assign bus.halted_o = (state == HALT);

endmodule

// File: tb/tb_accum_cpu_param.sv
// Directed bench for accum_cpu_param (DATA_W=8, ADDR_W=4, STEP_EN=1). Each step pushes the
// expected architectural state to a queue, clocks the command in, then pops and compares.
module tb_accum_cpu_param;

  localparam int DW = 8;
  localparam int AW = 4;

  localparam logic [1:0] LP = 2'd0, LD = 2'd1, SP = 2'd2, RUN = 2'd3;

  localparam logic [7:0] O_LOAD = 8'd0, O_STORE = 8'd1, O_ADD = 8'd2, O_MUL = 8'd3;
  localparam logic [7:0] O_SUB  = 8'd4, O_SHL = 8'd5,  O_SHR = 8'd6,  O_JIF = 8'd7;
  localparam logic [7:0] O_JZ   = 8'd8, O_JC  = 8'd9,  O_EQ  = 8'd10, O_NEQ = 8'd11;
  localparam logic [7:0] O_AND  = 8'd12, O_OR = 8'd13, O_NOT = 8'd14, O_HALT = 8'd15;

  typedef struct {
    string          tag;
    logic [DW-1:0]  acc;
    logic [AW-1:0]  pc;
    logic           z;
    logic           c;
    logic           h;
  } exp_t;

  logic clock;
  logic reset_n;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  accum_cpu_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  accum_cpu_param #(.DATA_W(DW), .ADDR_W(AW), .STEP_EN(1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge-op program: LOAD SHL SHR LOAD MUL EQ NEQ NOT AND OR SUB SUB JC - HALT
  logic [7:0] e_prog [15] = '{O_LOAD, O_SHL, O_SHR, O_LOAD, O_MUL, O_EQ, O_NEQ, O_NOT,
                              O_AND, O_OR, O_SUB, O_SUB, O_JC, O_LOAD, O_HALT};
  logic [7:0] e_data [15] = '{8'd1, 8'd200, 8'd200, 8'd16, 8'd16, 8'd0, 8'd1, 8'd0,
                              8'h0F, 8'hF0, 8'hFF, 8'd1, 8'd14, 8'd0, 8'd0};
  logic [7:0] x_acc  [14] = '{8'h01, 8'h80, 8'h01, 8'h10, 8'h00, 8'h01, 8'h00, 8'hFF,
                              8'h0F, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF};
  logic [3:0] x_pc   [14] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                              4'd9, 4'd10, 4'd11, 4'd12, 4'd14, 4'd14};
  logic       x_z    [14] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
  logic       x_c    [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
  logic       x_h    [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  task automatic push(input string tag, input logic [DW-1:0] acc, input logic [AW-1:0] pc,
                      input logic z, input logic c, input logic h);
    exp_t e;
    e.tag = tag; e.acc = acc; e.pc = pc; e.z = z; e.c = c; e.h = h;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=>0");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_assert++;
      assert (bus.acc_o === e.acc) else begin
        n_fail++; $error("FAIL %s acc observed=%0h expected=%0h", e.tag, bus.acc_o, e.acc);
      end
      n_assert++;
      assert (bus.pc_o === e.pc) else begin
        n_fail++; $error("FAIL %s pc observed=%0d expected=%0d", e.tag, bus.pc_o, e.pc);
      end
      n_assert++;
      assert (bus.zero_o === e.z) else begin
        n_fail++; $error("FAIL %s zero observed=%b expected=%b", e.tag, bus.zero_o, e.z);
      end
      n_assert++;
      assert (bus.carry_o === e.c) else begin
        n_fail++; $error("FAIL %s carry observed=%b expected=%b", e.tag, bus.carry_o, e.c);
      end
      n_assert++;
      assert (bus.halted_o === e.h) else begin
        n_fail++; $error("FAIL %s halted observed=%b expected=%b", e.tag, bus.halted_o, e.h);
      end
    end
  endtask

  task automatic cyc(input logic [1:0] cmd, input logic [7:0] d, input logic v, input logic st);
    bus.cmd_i   = cmd;
    bus.data_i  = d;
    bus.valid_i = v;
    bus.step_i  = st;
    @(posedge clock);
    #1;
  endtask

  task automatic ld(input logic [1:0] cmd, input logic [7:0] d);
    cyc(cmd, d, 1'b1, 1'b1);
  endtask

  task automatic step_chk(input logic [1:0] cmd, input logic [7:0] d, input logic v,
                          input logic st, input string tag, input logic [DW-1:0] acc,
                          input logic [AW-1:0] pc, input logic z, input logic c, input logic h);
    push(tag, acc, pc, z, c, h);
    cyc(cmd, d, v, st);
    check_pop();
  endtask

  task automatic do_reset(input string tag);
    bus.valid_i = 1'b0;
    #2;
    reset_n = 1'b0;
    push(tag, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check_pop();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Reset asserted between clock edges must clear the outputs without waiting for a clock.
  task automatic async_reset_chk(input string tag);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    push(tag, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check_pop();
    bus.valid_i = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    reset_n     = 1'b1;
    bus.cmd_i   = LP;
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    bus.cond_i  = 1'b0;
    bus.step_i  = 1'b0;

    // Load and run: 200 + 100 wraps to 44 with carry, then HALT
    do_reset("reset");
    ld(LP, O_LOAD); ld(LP, O_ADD); ld(LP, O_HALT);
    ld(SP, 8'd0);
    ld(LD, 8'd200); ld(LD, 8'd100);
    step_chk(SP,  8'd0, 1, 1, "setpc0",     8'd0,   4'd0, 0, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "run_load",   8'd200, 4'd1, 0, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "run_add",    8'd44,  4'd2, 0, 1, 0);
    step_chk(RUN, 8'd0, 1, 1, "run_halt",   8'd44,  4'd2, 0, 1, 1);
    step_chk(RUN, 8'd0, 1, 1, "halt_run",   8'd44,  4'd2, 0, 1, 1);
    step_chk(LD,  8'd7, 1, 1, "halt_ld",    8'd44,  4'd3, 0, 1, 1);
    step_chk(SP,  8'd0, 1, 1, "halt_setpc", 8'd44,  4'd0, 0, 1, 0);
    step_chk(RUN, 8'd0, 1, 1, "re_load",    8'd200, 4'd1, 0, 1, 0);
    step_chk(RUN, 8'd0, 1, 1, "re_add",     8'd44,  4'd2, 0, 1, 0);
    step_chk(RUN, 8'd0, 1, 1, "re_halt",    8'd44,  4'd2, 0, 1, 1);
    async_reset_chk("async_reset");

    // Countdown loop with cond_i held high
    bus.cond_i = 1'b1;
    ld(LP, O_LOAD); ld(LP, O_SUB); ld(LP, O_JZ); ld(LP, O_JIF);
    ld(SP, 8'd0);
    ld(LD, 8'd3); ld(LD, 8'd1); ld(LD, 8'd15); ld(LD, 8'd1);
    step_chk(SP,  8'd0, 1, 1, "loop_setpc", 8'd0, 4'd0,  0, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "loop_load",  8'd3, 4'd1,  0, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "loop_sub1",  8'd2, 4'd2,  0, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "loop_jz1",   8'd2, 4'd3,  0, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "loop_jif1",  8'd2, 4'd1,  0, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "loop_sub2",  8'd1, 4'd2,  0, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "loop_jz2",   8'd1, 4'd3,  0, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "loop_jif2",  8'd1, 4'd1,  0, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "loop_sub3",  8'd0, 4'd2,  1, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "loop_jz3",   8'd0, 4'd15, 1, 0, 0);
    bus.cond_i = 1'b0;
    step_chk(SP,  8'd3, 1, 1, "jif_setpc",  8'd0, 4'd3,  1, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "jif_nt",     8'd0, 4'd4,  1, 0, 0);

    // Single-step: step pattern 1,0,0,1 retires LOAD and SUB only
    bus.cond_i = 1'b1;
    step_chk(SP,  8'd0, 1, 1, "step_setpc", 8'd0, 4'd0, 1, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "step_1",     8'd3, 4'd1, 0, 0, 0);
    step_chk(RUN, 8'd0, 1, 0, "step_0a",    8'd3, 4'd1, 0, 0, 0);
    step_chk(RUN, 8'd0, 1, 0, "step_0b",    8'd3, 4'd1, 0, 0, 0);
    step_chk(RUN, 8'd0, 1, 1, "step_2",     8'd2, 4'd2, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step_chk(LP, 8'hFF, 0, 1, $sformatf("idle%0d", i), 8'd2, 4'd2, 0, 0, 0);

    // Address wrap and self-modifying STORE
    do_reset("reset2");
    ld(SP, 8'd15);
    step_chk(LD,  8'h5A, 1, 1, "wrap_ld",  8'h00, 4'd0, 0, 0, 0);
    ld(SP, 8'd15);
    step_chk(RUN, 8'd0,  1, 1, "wrap_run", 8'h5A, 4'd0, 0, 0, 0);
    ld(LP, O_STORE); ld(LP, O_LOAD);
    ld(SP, 8'd0);
    ld(LD, 8'd1); ld(LD, 8'h33);
    ld(SP, 8'd0);
    step_chk(RUN, 8'd0,  1, 1, "store",    8'h5A, 4'd1, 0, 0, 0);
    step_chk(RUN, 8'd0,  1, 1, "load_fwd", 8'h5A, 4'd2, 0, 0, 0);

    // Edge ops: shift clamp, MUL overflow, compares, logic, borrow, JC, HALT
    do_reset("reset3");
    for (int i = 0; i < 15; i++) ld(LP, e_prog[i]);
    ld(SP, 8'd0);
    for (int i = 0; i < 15; i++) ld(LD, e_data[i]);
    ld(SP, 8'd0);
    for (int i = 0; i < 14; i++)
      step_chk(RUN, 8'd0, 1, 1, $sformatf("edge%0d", i), x_acc[i], x_pc[i], x_z[i], x_c[i], x_h[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
